// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester, response and data-memory signals of data_mem_arbiter
interface data_mem_arbiter_if #(
    parameter int WORD_LEN = 32
);
    logic                a_req;
    logic                a_we;
    logic [WORD_LEN-1:0] a_addr;
    logic [WORD_LEN-1:0] a_wdata;
    logic                a_ack;
    logic                a_stall;

    logic                b_req;
    logic                b_we;
    logic [WORD_LEN-1:0] b_addr;
    logic [WORD_LEN-1:0] b_wdata;
    logic                b_ack;
    logic                b_stall;

    logic [WORD_LEN-1:0] rdata;
    logic                busy;

    logic                mem_writeEn;
    logic                mem_readEn;
    logic [WORD_LEN-1:0] mem_address;
    logic [WORD_LEN-1:0] mem_dataIn;
    logic [WORD_LEN-1:0] mem_dataOut;

    // Arbiter side
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        output a_ack, a_stall,
        input  b_req, b_we, b_addr, b_wdata,
        output b_ack, b_stall,
        output rdata, busy,
        output mem_writeEn, mem_readEn, mem_address, mem_dataIn,
        input  mem_dataOut
    );

    // Requesters and data memory side
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        input  a_ack, a_stall,
        output b_req, b_we, b_addr, b_wdata,
        input  b_ack, b_stall,
        input  rdata, busy,
        input  mem_writeEn, mem_readEn, mem_address, mem_dataIn,
        output mem_dataOut
    );
endinterface

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port data memory arbiter, round-robin contention when DMEM_ARB_RR_EN is defined
module data_mem_arbiter #(
    parameter int WORD_LEN    = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    data_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [3:0]          cnt;
    logic                owner_b;
    logic                last_owner_b;
    logic                lat_we;
    logic [WORD_LEN-1:0] lat_addr;
    logic [WORD_LEN-1:0] lat_wdata;
    logic [WORD_LEN-1:0] rdata_q;
    logic                grant_b;
    logic                any_req;
    logic                ack_a;
    logic                ack_b;

    assign any_req = bus.a_req | bus.b_req;

    // Winner selection when leaving IDLE; B only wins contention in round-robin mode after an A grant
`ifdef DMEM_ARB_RR_EN
    assign grant_b = bus.b_req & (~bus.a_req | ~last_owner_b);
`else
    assign grant_b = bus.b_req & ~bus.a_req;
`endif

    // State register; reset aborts any access in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and all combinational outputs; memory strobes depend only on state so reset drops them at once
    always_comb begin
        state_next      = state;
        ack_a           = 1'b0;
        ack_b           = 1'b0;
        bus.busy        = 1'b0;
        bus.mem_writeEn = 1'b0;
        bus.mem_readEn  = 1'b0;
        bus.mem_address = '0;
        bus.mem_dataIn  = '0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                bus.busy        = 1'b1;
                bus.mem_readEn  = ~lat_we;
                bus.mem_writeEn = lat_we & (cnt == 4'd0);
                bus.mem_address = lat_addr;
                bus.mem_dataIn  = lat_wdata;
                if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                bus.busy   = 1'b1;
                ack_a      = ~owner_b;
                ack_b      = owner_b;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch, access counter, read capture and last-owner bookkeeping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt          <= 4'd0;
            owner_b      <= 1'b0;
            last_owner_b <= 1'b1;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            rdata_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner_b   <= grant_b;
                        lat_we    <= grant_b ? bus.b_we    : bus.a_we;
                        lat_addr  <= grant_b ? bus.b_addr  : bus.a_addr;
                        lat_wdata <= grant_b ? bus.b_wdata : bus.a_wdata;
                        cnt       <= CNT_INIT;
                    end
                end
                ACCESS: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        rdata_q <= lat_we ? '0 : bus.mem_dataOut;
                    end
                end
                RESP: begin
                    last_owner_b <= owner_b;
                end
                default: begin
                    cnt <= 4'd0;
                end
            endcase
        end
    end

    assign bus.a_ack   = ack_a;
    assign bus.b_ack   = ack_b;
    assign bus.a_stall = bus.a_req & ~ack_a;
    assign bus.b_stall = bus.b_req & ~ack_b;
    assign bus.rdata   = rdata_q;

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Shares the single data memory between two requesters: port A (pipeline MEM stage) and port B (loader/debug master). Arbitrates, latches the winning request, sequences a fixed-latency memory access over a programmable number of cycles, and returns a one-cycle acknowledge with registered read data. Sits between the MEM stage/hazard unit and the data memory; the memory's `writeEn`/`readEn`/`address`/`dataIn`/`dataOut` connect directly to the `mem_*` ports.

## Interface
- `WORD_LEN`, 32, data/address width
- `WAIT_CYCLES`, 1, memory access cycles per transaction, legal 1..15
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `a_req`  in  1  port A request, held until `a_ack`
- `a_we`  in  1  port A write (1) / read (0)
- `a_addr`  in  WORD_LEN  port A byte address
- `a_wdata`  in  WORD_LEN  port A write data
- `a_ack`  out  1  one-cycle completion pulse for A
- `a_stall`  out  1  `a_req & ~a_ack`, combinational, to hazard unit
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`  same as port A for B
- `rdata`  out  WORD_LEN  read data, valid in the `*_ack` cycle
- `busy`  out  1  high in any state other than IDLE
- `mem_writeEn`  out  1,  `mem_readEn`  out  1,  `mem_address`  out  WORD_LEN,  `mem_dataIn`  out  WORD_LEN  drive data memory
- `mem_dataOut`  in  WORD_LEN  memory read data (combinational)

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any `*_req`, select winner, latch owner, `we`, `addr`, `wdata`; load `cnt = WAIT_CYCLES-1`; go ACCESS. No request: stay.
- ACCESS: `mem_address`/`mem_dataIn` from latched regs; `mem_readEn = ~we` every ACCESS cycle; `mem_writeEn = we & (cnt == 0)` (exactly one write edge per transaction). `cnt != 0`: decrement. `cnt == 0`: capture `mem_dataOut` into `rdata` (writes capture 0); go RESP.
- RESP: assert owner's `*_ack` for exactly one cycle; record owner as `last_owner`; go IDLE. Requests are ignored in RESP.
- Outside ACCESS all `mem_*` outputs are 0.
- `rdata` holds its value until the next capture.
- Requester must keep `req` and fields stable until ack; if `req` drops mid-transaction the access still completes and ack still pulses.
- Address passed unmodified; word alignment is the memory's job.

## Timing
- Reset (async, `rst` low): state IDLE, `cnt` 0, `rdata` 0, `last_owner` B, `a_ack`/`b_ack`/`busy`/all `mem_*` 0. Reset during ACCESS aborts immediately: `mem_writeEn` drops without a clock edge, no ack, pending write discarded if its edge has not occurred.
- Latency: request seen in IDLE at edge N -> ack high in cycle N+WAIT_CYCLES+1 (WAIT_CYCLES=1: ack two cycles after request sampled).
- Throughput: one transaction per WAIT_CYCLES+2 cycles; a requester holding `req` through ack re-arbitrates in the following IDLE cycle.
- Write occurs on the rising edge ending the last ACCESS cycle.
- Simultaneous `a_req` and `b_req` in IDLE: resolved per Configuration.

## Configuration
- `DMEM_ARB_RR_EN` defined: round-robin; on contention grant the port that is not `last_owner` (first contention after reset goes to A). Single requester always granted.
- Not defined: fixed priority, A always wins contention; B may starve; `last_owner` still maintained but unused.

## Test plan
- Reset, then A write `addr=0x400, wdata=0xDEADBEEF`, WAIT_CYCLES=1 -> one `mem_writeEn` pulse with `mem_address=0x400`, `a_ack` at request+2 cycles, `b_ack` never.
- A read of `0x400` after that write -> `rdata=0xDEADBEEF` with `a_ack`; `mem_writeEn` stays 0; `a_stall` high exactly 2 cycles.
- A and B request together continuously (with `DMEM_ARB_RR_EN`) -> acks alternate A,B,A,B; without macro -> only `a_ack`, B starved while A holds req.
- WAIT_CYCLES=4, B write -> `mem_readEn` 0, `mem_writeEn` high only in 4th ACCESS cycle, `b_ack` at request+5.
- `rst` asserted in 2nd ACCESS cycle of a 4-cycle write -> all `mem_*` 0 immediately, no ack, memory location unchanged, `busy` 0.
- `a_req` dropped after grant -> access completes, `a_ack` still pulses once, then IDLE.
